spi_txn_scheduler: RTL

Shares one SPI master core among N_REQ requesters. Each requester submits a transfer (32-bit config word plus one data byte). The block grants requesters round-robin, configures and sequences the core through data_config, i_data_p and trans_en, and waits for interupt_request. It then returns o_data_p to the granted requester, or flags a timeout error. It sits between the bus-side requesters and the SPI master core.

---
 rtl/spi_txn_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler that shares one SPI master core among N_REQ requesters.
// Each accepted transfer is loaded, started, awaited (with timeout) and answered.
module spi_txn_scheduler #(
    parameter int N_REQ   = 4,
    parameter int CFG_W   = 32,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*CFG_W-1:0]    req_cfg,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic [CFG_W-1:0]          data_config,
    output logic [DATA_W-1:0]         i_data_p,
    output logic                      trans_en,
    input  logic [DATA_W-1:0]         o_data_p,
    input  logic                      interupt_request,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id
);
    // state  | meaning
    // IDLE   | arbitrate pending requests, accept one
    // LOAD   | drive captured config/data onto the core
    // START  | pulse trans_en, clear timeout counter
    // WAIT   | wait for interupt_request or timeout
    // RESP   | pulse rsp_valid to the granted requester
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [CFG_W-1:0]  cap_cfg;
    logic [DATA_W-1:0] cap_data;
    logic              sel_found;
    logic [ID_W-1:0]   sel_idx;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return s[ID_W-1:0];
    endfunction

    // Scan downward so the smallest offset from rr_ptr is the one that sticks.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(rr_ptr, k)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_idx(rr_ptr, k);
            end
        end
    end

    // Pulses are gated by rst so nothing is accepted or reported while reset is held.
    assign req_ready = (rst && state == S_IDLE && sel_found) ? (N_REQ'(1) << sel_idx) : '0;
    assign rsp_valid = (rst && state == S_RESP) ? (N_REQ'(1) << grant_id) : '0;
    assign trans_en  = rst && (state == S_START);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            cap_cfg     <= '0;
            cap_data    <= '0;
            data_config <= '0;
            i_data_p    <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        cap_cfg  <= req_cfg[int'(sel_idx)*CFG_W +: CFG_W];
                        cap_data <= req_data[int'(sel_idx)*DATA_W +: DATA_W];
                        grant_id <= sel_idx;
                        rr_ptr   <= wrap_idx(sel_idx, 1);
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    data_config <= cap_cfg;
                    i_data_p    <= cap_data;
                    state       <= S_START;
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (interupt_request) begin
                        rsp_data <= o_data_p;
                        rsp_err  <= 1'b0;
                        state    <= S_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
